// File: rtl/pong_pkg.sv
// Shared geometry, timing constants and state encoding for the PONG game sequencer.
package pong_pkg;

  localparam int unsigned H_VIS        = 640;
  localparam int unsigned V_VIS        = 480;
  localparam int unsigned BALL_SIZE    = 8;
  localparam int unsigned BALL_SPEED   = 4;
  localparam int unsigned PADDLE_H     = 64;
  localparam int unsigned PADDLE_W     = 8;
  localparam int unsigned PADDLE_SPEED = 4;
  localparam int unsigned PADDLE_L_X   = 16;
  localparam int unsigned PADDLE_R_X   = 616;
  localparam int unsigned SERVE_FRAMES = 60;
  localparam int unsigned POINT_FRAMES = 90;
  localparam int unsigned WIN_SCORE    = 9;

  // Derived positions: centres, clamps and paddle-face bounce columns.
  localparam logic [9:0] BALL_X0      = 10'((H_VIS - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_Y0      = 10'((V_VIS - BALL_SIZE) / 2);
  localparam logic [9:0] PADDLE_Y0    = 10'((V_VIS - PADDLE_H) / 2);
  localparam logic [9:0] PADDLE_Y_MAX = 10'(V_VIS - PADDLE_H);
  localparam logic [9:0] BALL_Y_MAX   = 10'(V_VIS - BALL_SIZE);
  localparam logic [9:0] BALL_X_L     = 10'(PADDLE_L_X + PADDLE_W);
  localparam logic [9:0] BALL_X_R     = 10'(PADDLE_R_X - BALL_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_t;

  function automatic logic [3:0] score_inc(input logic [3:0] s);
    return (s >= 4'(WIN_SCORE)) ? 4'(WIN_SCORE) : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: vertical position register with clamped up/down motion and a recentre load.
module pong_paddle
  import pong_pkg::*;
(
  input  logic       clock,
  input  logic       rst,
  input  logic       move_i,
  input  logic       center_i,
  input  logic       up_i,
  input  logic       dn_i,
  output logic [9:0] y_o
);

  logic [9:0] y_q, y_d;

  // Bounds are checked before the add/subtract so the 10-bit value never wraps.
  always_comb begin
    y_d = y_q;
    if (center_i) begin
      y_d = PADDLE_Y0;
    end else if (move_i && up_i && !dn_i) begin
      y_d = (y_q < 10'(PADDLE_SPEED)) ? 10'd0 : y_q - 10'(PADDLE_SPEED);
    end else if (move_i && dn_i && !up_i) begin
      y_d = ({1'b0, y_q} + 11'(PADDLE_SPEED) > 11'(V_VIS - PADDLE_H)) ?
            PADDLE_Y_MAX : y_q + 10'(PADDLE_SPEED);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) y_q <= PADDLE_Y0;
    else     y_q <= y_d;
  end

  assign y_o = y_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-synchronous PONG sequencer: game FSM, ball motion/collision and scoring.
// All state advances only on frame_tick, so the renderer never sees mid-frame motion.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       clock,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_l_y,
  output logic [9:0] paddle_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] game_state,
  output logic       game_over
);

  game_state_t state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic        dir_x_q, dir_x_d;   // 1 = moving right
  logic        dir_y_q, dir_y_d;   // 1 = moving down
  logic [3:0]  score_l_q, score_l_d, score_r_q, score_r_d;
  logic        paddle_move, paddle_center;

  pong_paddle u_paddle_l (
    .clock    (clock),
    .rst      (rst),
    .move_i   (paddle_move),
    .center_i (paddle_center),
    .up_i     (btn_l_up),
    .dn_i     (btn_l_dn),
    .y_o      (paddle_l_y)
  );

  pong_paddle u_paddle_r (
    .clock    (clock),
    .rst      (rst),
    .move_i   (paddle_move),
    .center_i (paddle_center),
    .up_i     (btn_r_up),
    .dn_i     (btn_r_dn),
    .y_o      (paddle_r_y)
  );

  // Candidate ball step; collisions use the paddle positions held before this tick.
  logic [10:0] bx, by, pl, pr, nx;
  logic [9:0]  step_x, step_y;
  logic        step_dx, step_dy, miss_l, miss_r, overlap_l, overlap_r;

  assign bx = {1'b0, ball_x_q};
  assign by = {1'b0, ball_y_q};
  assign pl = {1'b0, paddle_l_y};
  assign pr = {1'b0, paddle_r_y};
  assign overlap_l = (by + 11'(BALL_SIZE) > pl) && (by < pl + 11'(PADDLE_H));
  assign overlap_r = (by + 11'(BALL_SIZE) > pr) && (by < pr + 11'(PADDLE_H));

  always_comb begin
    step_y  = ball_y_q;
    step_dy = dir_y_q;
    step_x  = ball_x_q;
    step_dx = dir_x_q;
    miss_l  = 1'b0;
    miss_r  = 1'b0;
    nx      = bx;
    if (dir_y_q) begin
      if (by + 11'(BALL_SPEED) > 11'(V_VIS - BALL_SIZE)) begin
        step_y  = BALL_Y_MAX;
        step_dy = 1'b0;
      end else begin
        step_y = ball_y_q + 10'(BALL_SPEED);
      end
    end else begin
      if (by < 11'(BALL_SPEED)) begin
        step_y  = 10'd0;
        step_dy = 1'b1;
      end else begin
        step_y = ball_y_q - 10'(BALL_SPEED);
      end
    end
    if (dir_x_q) begin
      nx = bx + 11'(BALL_SPEED);
      if (nx + 11'(BALL_SIZE) >= 11'(PADDLE_R_X)) begin
        step_x = BALL_X_R;
        if (overlap_r) step_dx = 1'b0;
        else           miss_r  = 1'b1;
      end else begin
        step_x = nx[9:0];
      end
    end else begin
      nx = (bx < 11'(BALL_SPEED)) ? 11'd0 : bx - 11'(BALL_SPEED);
      if (nx <= 11'(PADDLE_L_X + PADDLE_W)) begin
        step_x = BALL_X_L;
        if (overlap_l) step_dx = 1'b1;
        else           miss_l  = 1'b1;
      end else begin
        step_x = nx[9:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    paddle_move   = 1'b0;
    paddle_center = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SERVE;
          cnt_d    = '0;
          ball_x_d = BALL_X0;
          ball_y_d = BALL_Y0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          paddle_move = 1'b1;
          if (cnt_q == 7'(SERVE_FRAMES - 1)) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          paddle_move = 1'b1;
          ball_x_d    = step_x;
          ball_y_d    = step_y;
          dir_x_d     = step_dx;
          dir_y_d     = step_dy;
          cnt_d       = '0;
          // A miss leaves dir_x pointing at the conceding side, which is who gets served.
          if (miss_r) begin
            score_l_d = score_inc(score_l_q);
            state_d   = (score_inc(score_l_q) == 4'(WIN_SCORE)) ? ST_GAME_OVER : ST_POINT;
          end else if (miss_l) begin
            score_r_d = score_inc(score_r_q);
            state_d   = (score_inc(score_r_q) == 4'(WIN_SCORE)) ? ST_GAME_OVER : ST_POINT;
          end
        end
      end
      ST_POINT: begin
        if (frame_tick) begin
          paddle_move = 1'b1;
          if (cnt_q == 7'(POINT_FRAMES - 1)) begin
            state_d  = ST_SERVE;
            cnt_d    = '0;
            ball_x_d = BALL_X0;
            ball_y_d = BALL_Y0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      ST_GAME_OVER: begin
        if (start) begin
          state_d       = ST_SERVE;
          cnt_d         = '0;
          score_l_d     = '0;
          score_r_d     = '0;
          ball_x_d      = BALL_X0;
          ball_y_d      = BALL_Y0;
          paddle_center = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ball_x_q  <= BALL_X0;
      ball_y_q  <= BALL_Y0;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      score_l_q <= '0;
      score_r_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end

  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign game_state = state_q;
  assign game_over  = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: serve/play/point sequencing, paddle clamps,
// bounces, misses, game over and reset priority, against hand-computed positions.
module tb_pong_game_ctrl;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0, start = 1'b0;
  logic       btn_l_up = 1'b0, btn_l_dn = 1'b0, btn_r_up = 1'b0, btn_r_dn = 1'b0;
  logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
  logic [3:0] score_l, score_r;
  logic [2:0] game_state;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pong_game_ctrl dut (
    .clock      (clock),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .btn_l_up   (btn_l_up),
    .btn_l_dn   (btn_l_dn),
    .btn_r_up   (btn_r_up),
    .btn_r_dn   (btn_r_dn),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle_l_y (paddle_l_y),
    .paddle_r_y (paddle_r_y),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_state (game_state),
    .game_over  (game_over)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge after the tick.
  task automatic tick();
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic check_ball(input string tag, input logic [31:0] x, input logic [31:0] y);
    check_eq({tag, "_ball_x"}, 32'(ball_x), x);
    check_eq({tag, "_ball_y"}, 32'(ball_y), y);
  endtask

  task automatic check_reset_vals(input string tag);
    check_ball(tag, 316, 236);
    check_eq({tag, "_paddle_l"}, 32'(paddle_l_y), 208);
    check_eq({tag, "_paddle_r"}, 32'(paddle_r_y), 208);
    check_eq({tag, "_score_l"}, 32'(score_l), 0);
    check_eq({tag, "_score_r"}, 32'(score_r), 0);
    check_eq({tag, "_state"}, 32'(game_state), 0);
    check_eq({tag, "_game_over"}, 32'(game_over), 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    rst = 1'b0;
    check_reset_vals("reset");
    ticks(5);
    check_reset_vals("idle_ticks");

    // First serve: 60 ticks, still centred on the transition tick.
    pulse_start();
    check_eq("serve_entry", 32'(game_state), 1);
    ticks(59);
    check_eq("serve_t59", 32'(game_state), 1);
    tick();
    check_eq("serve_t60", 32'(game_state), 2);
    check_ball("serve_t60", 316, 236);

    // First play: down-right, no buttons.
    tick();
    check_ball("play1_k1", 320, 240);
    repeat (4) @(negedge clock);
    check_eq("hold_between_ticks", 32'(ball_x), 320);
    ticks(58);
    check_ball("play1_k59", 552, 472);
    tick();
    check_ball("play1_k60_dwell", 556, 472);
    tick();
    check_ball("play1_k61_up", 560, 468);
    ticks(11);
    check_eq("play1_k72_x", 32'(ball_x), 604);
    check_eq("play1_k72_state", 32'(game_state), 2);
    tick();
    check_ball("miss_r", 608, 420);
    check_eq("miss_r_score_l", 32'(score_l), 1);
    check_eq("miss_r_score_r", 32'(score_r), 0);
    check_eq("miss_r_state", 32'(game_state), 3);

    // Point hold, then re-serve from centre.
    ticks(89);
    check_eq("point_t89_state", 32'(game_state), 3);
    check_ball("point_frozen", 608, 420);
    tick();
    check_eq("point_t90_state", 32'(game_state), 1);
    check_ball("reserve", 316, 236);
    check_eq("reserve_score_l", 32'(score_l), 1);

    // Left paddle driven up through the second serve: 208 -> 0 in 52 ticks.
    btn_l_up = 1'b1;
    ticks(51);
    check_eq("pl_up_t51", 32'(paddle_l_y), 4);
    tick();
    check_eq("pl_up_t52", 32'(paddle_l_y), 0);
    ticks(8);
    check_eq("pl_up_t60", 32'(paddle_l_y), 0);
    check_eq("serve2_done", 32'(game_state), 2);
    btn_l_up = 1'b0;

    // Second play: ball up-right. Right paddle driven up to meet its path.
    btn_r_up = 1'b1;
    btn_l_dn = 1'b1;
    ticks(10);
    check_eq("pl_dn_t10", 32'(paddle_l_y), 40);
    check_eq("pr_up_t10", 32'(paddle_r_y), 168);
    check_ball("play2_k10", 356, 196);
    btn_l_up = 1'b1;
    ticks(5);
    check_eq("pl_both", 32'(paddle_l_y), 40);
    btn_l_up = 1'b0;
    btn_l_dn = 1'b0;
    ticks(37);
    check_eq("pr_up_top", 32'(paddle_r_y), 0);
    ticks(20);
    check_ball("play2_k72", 604, 48);
    tick();
    check_ball("bounce_r", 608, 52);
    check_eq("bounce_r_score_l", 32'(score_l), 1);
    check_eq("bounce_r_state", 32'(game_state), 2);
    tick();
    check_ball("bounce_r_next", 604, 56);

    // Ball travels left, bounces off the bottom, misses the left paddle at y=40.
    ticks(144);
    check_ball("play2_k218", 28, 316);
    check_eq("play2_k218_state", 32'(game_state), 2);
    tick();
    btn_r_up = 1'b0;
    check_ball("miss_l", 24, 312);
    check_eq("miss_l_score_r", 32'(score_r), 1);
    check_eq("miss_l_score_l", 32'(score_l), 1);
    check_eq("miss_l_state", 32'(game_state), 3);
    ticks(90);
    check_eq("serve3_state", 32'(game_state), 1);
    check_ball("serve3", 316, 236);
    ticks(60);
    check_eq("play3_state", 32'(game_state), 2);
    ticks(3);
    check_ball("play3_k3_left_up", 304, 224);

    // Reset coincident with a tick and start during play.
    @(negedge clock);
    rst = 1'b1; frame_tick = 1'b1; start = 1'b1; btn_l_dn = 1'b1;
    @(negedge clock);
    rst = 1'b0; frame_tick = 1'b0; start = 1'b0; btn_l_dn = 1'b0;
    check_reset_vals("midplay_rst");

    // start and tick together in IDLE: transition only, no paddle motion.
    @(negedge clock);
    start = 1'b1; frame_tick = 1'b1; btn_l_up = 1'b1;
    @(negedge clock);
    start = 1'b0; frame_tick = 1'b0; btn_l_up = 1'b0;
    check_eq("idle_start_tick_state", 32'(game_state), 1);
    check_eq("idle_start_tick_pl", 32'(paddle_l_y), 208);
    check_ball("idle_start_tick", 316, 236);

    // Nine rounds with idle paddles: every serve misses on the right.
    for (int r = 1; r <= 9; r++) begin
      if (r == 9) btn_l_dn = 1'b1;
      ticks(30);
      if (r == 1) pulse_start();
      ticks(29);
      check_eq($sformatf("r%0d_serve_t59", r), 32'(game_state), 1);
      tick();
      btn_l_dn = 1'b0;
      check_eq($sformatf("r%0d_play", r), 32'(game_state), 2);
      ticks(72);
      check_eq($sformatf("r%0d_k72", r), 32'(game_state), 2);
      tick();
      check_eq($sformatf("r%0d_score_l", r), 32'(score_l), 32'(r));
      check_eq($sformatf("r%0d_score_r", r), 32'(score_r), 0);
      if (r < 9) begin
        check_eq($sformatf("r%0d_point", r), 32'(game_state), 3);
        ticks(90);
        check_eq($sformatf("r%0d_reserve", r), 32'(game_state), 1);
      end else begin
        check_eq("win_state", 32'(game_state), 4);
        check_eq("win_game_over", 32'(game_over), 1);
      end
    end

    // Game over freezes everything, even with buttons held.
    btn_l_up = 1'b1; btn_r_dn = 1'b1;
    ticks(20);
    btn_l_up = 1'b0; btn_r_dn = 1'b0;
    check_ball("frozen", 608, 420);
    check_eq("frozen_pl", 32'(paddle_l_y), 416);
    check_eq("frozen_pr", 32'(paddle_r_y), 208);
    check_eq("frozen_score_l", 32'(score_l), 9);
    check_eq("frozen_score_r", 32'(score_r), 0);
    check_eq("frozen_state", 32'(game_state), 4);
    check_eq("frozen_game_over", 32'(game_over), 1);

    pulse_start();
    check_eq("restart_state", 32'(game_state), 1);
    check_eq("restart_score_l", 32'(score_l), 0);
    check_eq("restart_score_r", 32'(score_r), 0);
    check_ball("restart", 316, 236);
    check_eq("restart_pl", 32'(paddle_l_y), 208);
    check_eq("restart_game_over", 32'(game_over), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
